segway_pid: RTL and testbench
=============================

SEGWAY_PID -- requirements
Module: segway_pid

Interface
REQ-001 Parameter: fast_sim, default 1, selects soft-start ramp increment: 256 when 1, 1 when 0.
REQ-002 clk  input  1  system clock; all flops are rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 vld  input  1  one-clock strobe; ptch and ptch_rt are valid for that cycle.
REQ-005 ptch  input  16  signed fused pitch.
REQ-006 ptch_rt  input  16  signed pitch rate.
REQ-007 pwr_up  input  1  level; rider has powered the unit on.
REQ-008 rider_off  input  1  level; no rider weight is detected.
REQ-009 PID_cntrl  output  12  signed, saturated, registered control effort.
REQ-010 out_vld  output  1  one-clock strobe marking a new PID_cntrl value.
REQ-011 ss_tmr  output  8  unsigned soft-start scale, 0 to 255.

Function
REQ-012 State machine: OFF, SOFT, RUN.
- Any state goes to OFF when pwr_up=0.
- OFF goes to SOFT when pwr_up=1.
- SOFT goes to RUN when ss_tmr=255.
- RUN holds while pwr_up=1.
REQ-013 Soft-start counter, 24 bits unsigned:
- cleared while in OFF;
- otherwise adds the increment from REQ-001 each clock;
- saturates at 0xFFFFFF and never wraps.
REQ-014 ss_tmr SHALL equal soft-start counter bits [23:16].
REQ-015 Pitch error SHALL be ptch saturated to 10-bit signed: below -512 gives -512, above 511 gives 511.
REQ-016 P_term SHALL be the pitch error times the constant 12, signed, 15 bits.
REQ-017 Integrator, 18 bits signed:
- On vld with pwr_up=1 and rider_off=0, it SHALL add the sign-extended pitch error.
- If both operands have the same sign and the result sign differs, the integrator SHALL hold its old value.
REQ-018 The integrator SHALL clear on any clock where rider_off=1 or the state is OFF; clear wins over a coincident vld.
REQ-019 I_term SHALL be the integrator value from before the current update, arithmetic-shifted right 6.
REQ-020 D_term SHALL be the negation of (ptch_rt arithmetic-shifted right 6), signed.
REQ-021 Sum:
- P_term, I_term and D_term SHALL be sign-extended to 16 bits and added.
- The sum SHALL saturate to 12-bit signed: -2048 to 2047.
REQ-022 On the clock after vld, PID_cntrl SHALL load the saturated sum and out_vld SHALL be 1 for exactly that clock.
REQ-023 In OFF state, PID_cntrl SHALL load 0 on vld; out_vld still pulses.
REQ-024 PID_cntrl SHALL hold its value between vld strobes.
REQ-025 If vld arrives on consecutive clocks, every strobe SHALL produce its own out_vld, one clock later.

Reset
REQ-026 When rst=1, asynchronously:
- PID_cntrl=0, out_vld=0, ss_tmr=0;
- integrator=0, soft-start counter=0;
- state=OFF.
REQ-027 A reset mid-ramp or mid-update SHALL discard all accumulated state; the first out_vld after reset needs a new vld.

Configuration
REQ-028 Macro PID_I_TERM_EN:
- Defined: the integrator and I_term exist as specified.
- Undefined: no integrator flops are built and I_term=0.
- All other behaviour is identical either way.

Verification
REQ-029 Bench scenarios:
- Proportional: pwr_up=1, rider_off=1, ptch=100, ptch_rt=0, vld pulse -> PID_cntrl=1200 and out_vld=1 one clock after vld.
- Saturation: rider_off=1, ptch=1000, ptch_rt=0, vld -> pitch error 511, P=6132, PID_cntrl=2047; ptch=-1000 -> PID_cntrl=-2048.
- Derivative: rider_off=1, ptch=0, ptch_rt=640, vld -> PID_cntrl=-10.
- Integrator (macro defined): rider_off=0, ptch=64, ptch_rt=0, nine vld pulses -> 9th output=776 (768+8); raising rider_off -> next output=768.
- Soft start (fast_sim=1): raise pwr_up -> ss_tmr=255 and state RUN after 65280 clocks; counter stays at 0xFFFFFF; dropping pwr_up -> ss_tmr=0 next clock and PID_cntrl=0 on next vld.
- Reset: assert rst mid-ramp with integrator nonzero -> all outputs 0 immediately; no out_vld until the next vld.

Source files
------------

// File: rtl/segway_pid.sv
// Segway balance PID: saturated P/I/D effort with an OFF/SOFT/RUN power-up sequencer and soft-start ramp.
// Optional integrator is built only when PID_I_TERM_EN is defined.
module segway_pid #(
    parameter bit fast_sim = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic signed [15:0] ptch_rt,
    input  logic               pwr_up,
    input  logic               rider_off,
    output logic signed [11:0] PID_cntrl,
    output logic               out_vld,
    output logic        [7:0]  ss_tmr
);

    localparam logic [23:0] SS_INC = fast_sim ? 24'd256 : 24'd1;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SOFT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic        [23:0] r_ss_cnt;
    logic        [24:0] w_ss_sum;
    logic signed [9:0]  w_ptch_err;
    logic signed [14:0] w_p_term;
    logic signed [15:0] w_i_term;
    logic signed [15:0] w_d_term;
    logic signed [15:0] w_sum;
    logic signed [11:0] w_pid_sat;
    logic signed [11:0] r_pid;
    logic               r_out_vld;

    // ------------------------------------------------------------------
    // Power-up sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!pwr_up) begin
            w_state_next = OFF;
        end else begin
            case (r_state)
                OFF:     w_state_next = SOFT;
                SOFT:    if (ss_tmr == 8'hFF) w_state_next = RUN;
                RUN:     w_state_next = RUN;
                default: w_state_next = OFF;
            endcase
        end
    end

    // Clearing on the next state lets ss_tmr drop the very clock pwr_up falls
    // and start ramping on the first clock after pwr_up rises.
    assign w_ss_sum = {1'b0, r_ss_cnt} + {1'b0, SS_INC};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_cnt <= '0;
        end else if (w_state_next == OFF) begin
            r_ss_cnt <= '0;
        end else if (w_ss_sum[24]) begin
            r_ss_cnt <= 24'hFF_FFFF;
        end else begin
            r_ss_cnt <= w_ss_sum[23:0];
        end
    end

    assign ss_tmr = r_ss_cnt[23:16];

    // ------------------------------------------------------------------
    // Error terms
    // ------------------------------------------------------------------
    always_comb begin
        w_ptch_err = ptch[9:0];
        if (ptch < -16'sd512) begin
            w_ptch_err = -10'sd512;
        end else if (ptch > 16'sd511) begin
            w_ptch_err = 10'sd511;
        end
    end

    assign w_p_term = $signed({{5{w_ptch_err[9]}}, w_ptch_err}) * 15'sd12;

    // Shift first, then negate in 16 bits so that -(-512) is representable.
    assign w_d_term = 16'sd0 - $signed({{6{ptch_rt[15]}}, ptch_rt[15:6]});

`ifdef PID_I_TERM_EN
    logic signed [17:0] r_integ;
    logic signed [17:0] w_integ_sum;
    logic               w_integ_ovf;

    assign w_integ_sum = r_integ + $signed({{8{w_ptch_err[9]}}, w_ptch_err});
    assign w_integ_ovf = (r_integ[17] == w_ptch_err[9]) && (w_integ_sum[17] != r_integ[17]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_integ <= '0;
        end else if (rider_off || r_state == OFF) begin
            r_integ <= '0;
        end else if (vld && pwr_up && !w_integ_ovf) begin
            r_integ <= w_integ_sum;
        end
    end

    // I_term uses the pre-update integrator value.
    assign w_i_term = {{4{r_integ[17]}}, r_integ[17:6]};

    logic w_unused;
    assign w_unused = ^ptch_rt[5:0];
`else
    assign w_i_term = '0;

    logic w_unused;
    assign w_unused = ^{ptch_rt[5:0], rider_off};
`endif

    // ------------------------------------------------------------------
    // Sum, saturation and output register
    // ------------------------------------------------------------------
    assign w_sum = $signed({w_p_term[14], w_p_term}) + w_i_term + w_d_term;

    always_comb begin
        w_pid_sat = w_sum[11:0];
        if (w_sum > 16'sd2047) begin
            w_pid_sat = 12'sd2047;
        end else if (w_sum < -16'sd2048) begin
            w_pid_sat = -12'sd2048;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pid     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= vld;
            if (vld) begin
                r_pid <= (r_state == OFF) ? 12'sd0 : w_pid_sat;
            end
        end
    end

    assign PID_cntrl = r_pid;
    assign out_vld   = r_out_vld;

endmodule

// File: tb/tb_segway_pid.sv
// Self-checking bench for segway_pid: table-driven P/D vectors plus sequences for
// back-to-back strobes, integrator, async reset and soft-start ramp.
module tb_segway_pid;

    logic               clk;
    logic               rst;
    logic               vld;
    logic signed [15:0] ptch;
    logic signed [15:0] ptch_rt;
    logic               pwr_up;
    logic               rider_off;
    logic signed [11:0] PID_cntrl;
    logic               out_vld;
    logic        [7:0]  ss_tmr;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PID_I_TERM_EN
    localparam int I_EN = 1;
`else
    localparam int I_EN = 0;
`endif

    segway_pid #(.fast_sim(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .PID_cntrl (PID_cntrl),
        .out_vld   (out_vld),
        .ss_tmr    (ss_tmr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Apply one vld strobe at a falling edge and check the result one clock later.
    task automatic pulse(input string name, input logic r_off, input logic signed [15:0] p,
                         input logic signed [15:0] pr, input int exp);
        rider_off = r_off;
        ptch      = p;
        ptch_rt   = pr;
        vld       = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        check({name, " out_vld"}, int'(out_vld), 1);
        check({name, " PID"}, int'(PID_cntrl), exp);
    endtask

    typedef struct {
        string              name;
        logic               r_off;
        logic signed [15:0] p;
        logic signed [15:0] pr;
        int                 exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"prop100",   1'b1, 16'sd100,   16'sd0,    1200};
        vecs[1]  = '{"sat_pos",   1'b1, 16'sd1000,  16'sd0,    2047};
        vecs[2]  = '{"sat_neg",   1'b1, -16'sd1000, 16'sd0,   -2048};
        vecs[3]  = '{"deriv640",  1'b1, 16'sd0,     16'sd640,  -10};
        vecs[4]  = '{"deriv-640", 1'b1, 16'sd0,    -16'sd640,   10};
        vecs[5]  = '{"err511",    1'b1, 16'sd511,   16'sd0,    2047};
        vecs[6]  = '{"prop-20",   1'b1, -16'sd20,   16'sd0,    -240};
        vecs[7]  = '{"p_and_d",   1'b1, 16'sd30,   -16'sd128,   362};
        vecs[8]  = '{"p170",      1'b1, 16'sd170,   16'sd0,    2040};
        vecs[9]  = '{"p171",      1'b1, 16'sd171,   16'sd0,    2047};
        vecs[10] = '{"p-171",     1'b1, -16'sd171,  16'sd0,   -2048};
        vecs[11] = '{"rt63",      1'b1, 16'sd5,     16'sd63,     60};
        vecs[12] = '{"rt-1",      1'b1, 16'sd5,    -16'sd1,      61};

        rst = 1'b1; vld = 1'b0; ptch = '0; ptch_rt = '0; pwr_up = 1'b0; rider_off = 1'b1;
        repeat (2) @(negedge clk);
        check("reset PID", int'(PID_cntrl), 0);
        check("reset out_vld", int'(out_vld), 0);
        check("reset ss_tmr", int'(ss_tmr), 0);
        rst = 1'b0;

        pwr_up = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            pulse(vecs[i].name, vecs[i].r_off, vecs[i].p, vecs[i].pr, vecs[i].exp);
            @(negedge clk);
            check({vecs[i].name, " strobe_drop"}, int'(out_vld), 0);
            check({vecs[i].name, " hold"}, int'(PID_cntrl), vecs[i].exp);
        end

        // Back-to-back strobes
        rider_off = 1'b1; ptch = 16'sd100; ptch_rt = '0; vld = 1'b1;
        @(negedge clk);
        check("b2b#1 out_vld", int'(out_vld), 1);
        check("b2b#1 PID", int'(PID_cntrl), 1200);
        ptch = -16'sd20;
        @(negedge clk);
        vld = 1'b0;
        check("b2b#2 out_vld", int'(out_vld), 1);
        check("b2b#2 PID", int'(PID_cntrl), -240);
        @(negedge clk);
        check("b2b end out_vld", int'(out_vld), 0);

        // Integrator: nine strobes of ptch=64 from a cleared integrator
        for (int k = 1; k <= 9; k++) begin
            pulse($sformatf("integ#%0d", k), 1'b0, 16'sd64, 16'sd0, 768 + I_EN * (k - 1));
            @(negedge clk);
        end
        rider_off = 1'b1;
        @(negedge clk);
        pulse("integ cleared", 1'b1, 16'sd64, 16'sd0, 768);
        @(negedge clk);

        // Async reset mid-ramp, with the integrator loaded and a strobe in flight
        repeat (600) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            pulse("pre-rst", 1'b0, 16'sd64, 16'sd0, 768 + I_EN * k);
            @(negedge clk);
        end
        check("pre-rst ss_tmr nonzero", int'(ss_tmr != 8'd0), 1);
        vld = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async rst PID", int'(PID_cntrl), 0);
        check("async rst out_vld", int'(out_vld), 0);
        check("async rst ss_tmr", int'(ss_tmr), 0);
        @(negedge clk);
        check("in rst out_vld", int'(out_vld), 0);
        rst = 1'b0;
        vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post-rst idle%0d out_vld", k), int'(out_vld), 0);
        end
        pulse("post-rst integ", 1'b0, 16'sd64, 16'sd0, 768);
        @(negedge clk);

        // Power down, then soft-start ramp
        pwr_up = 1'b0;
        @(negedge clk);
        check("pwr_down ss_tmr", int'(ss_tmr), 0);
        pulse("off state", 1'b1, 16'sd100, 16'sd0, 0);
        @(negedge clk);

        begin
            int n;
            n = 0;
            pwr_up = 1'b1;
            while (n < 70000) begin
                @(negedge clk);
                n++;
                if (ss_tmr == 8'hFF) break;
            end
            check("ramp clocks", n, 65280);
        end
        repeat (300) @(negedge clk);
        check("ramp saturated ss_tmr", int'(ss_tmr), 255);
        pulse("run state", 1'b1, 16'sd100, 16'sd0, 1200);
        @(negedge clk);
        check("run hold ss_tmr", int'(ss_tmr), 255);

        pwr_up = 1'b0;
        @(negedge clk);
        check("drop pwr ss_tmr", int'(ss_tmr), 0);
        pulse("drop pwr PID", 1'b1, 16'sd100, 16'sd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
